// File: rtl/display_convert_scheduler.sv
// Round-robin scheduler in front of a shared iterative binary-to-decimal engine.
// Publishes a complete, leading-zero-blanked digit set once per conversion.
module display_convert_scheduler #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 20,
    parameter int N_DIGITS = 6,
    localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_value,
    input  logic                      cancel,
    output logic [N_REQ-1:0]          grant,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    output logic                      done,
    output logic [N_DIGITS*4-1:0]     digits,
    output logic                      digits_valid,
    output logic                      overflow
);

    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int DW = N_DIGITS * 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [OW-1:0]     rr, win, pick;
    logic              found;
    logic [DATA_W-1:0] work, quo;
    logic [3:0]        rem;
    logic [DW-1:0]     shreg, full, blanked;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              lead;
    int                idx;

    // First set request at or above the rr pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    assign quo  = work / DATA_W'(10);
    assign rem  = 4'(work % DATA_W'(10));
    assign last = (cnt == CW'(N_DIGITS - 1));
    // Digits enter at the top so digit 0 lands at the bottom after N_DIGITS shifts.
    assign full = {rem, shreg[DW-1:4]};
    assign busy = (state != S_IDLE);

    always_comb begin
        blanked = full;
        lead    = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (lead && full[4*k +: 4] == 4'd0)
                blanked[4*k +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (found) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_CONV;
            S_CONV:  if (last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (cancel) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr           <= '0;
            win          <= '0;
            work         <= '0;
            shreg        <= '0;
            cnt          <= '0;
            grant        <= '0;
            done         <= 1'b0;
            owner        <= '0;
            digits       <= '1;
            digits_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state <= state_nx;
            grant <= '0;
            done  <= 1'b0;
            if (cancel) begin
                digits       <= '1;
                digits_valid <= 1'b0;
                overflow     <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (found) begin
                            grant <= N_REQ'(1) << pick;
                            win   <= pick;
                            rr    <= (pick == OW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                        end
                    end
                    S_LOAD: begin
                        work  <= req_value[int'(win)*DATA_W +: DATA_W];
                        shreg <= '0;
                        cnt   <= '0;
                    end
                    S_CONV: begin
                        work  <= quo;
                        shreg <= full;
                        cnt   <= cnt + 1'b1;
                        // Publish everything on the same edge so readers never see a mix.
                        if (last) begin
                            digits       <= blanked;
                            owner        <= win;
                            overflow     <= (quo != '0);
                            digits_valid <= 1'b1;
                            done         <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
